// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time and period capture with stuck detection
// Measures rise-fall-rise sequences and hands results to a valid/ready consumer.
module pwm_capture #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   input  logic             meas_ready,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_high,
   output logic [CNT_W-1:0] meas_period,
   output logic             stuck,
   output logic             stuck_level,
   output logic             overrun,
   input  logic             clr_overrun
);

   localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   p;
   logic                   rise;
   logic                   fall;

   state_t                 state;
   state_t                 state_nx;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nx;
   logic [CNT_W-1:0]       cnt_inc;
   logic [CNT_W-1:0]       hi;
   logic [CNT_W-1:0]       hi_nx;
   logic                   complete;
   logic                   timeout;
   logic                   drop;

   // Flops preset to 1 so a low input right after reset reads as a fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         p      <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         p      <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~p;
   assign fall = ~s & p;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         hi    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         hi    <= hi_nx;
      end
   end

   // Saturating increment keeps cnt at or below TIMEOUT.
   assign cnt_inc = (cnt == TIMEOUT_V) ? cnt : cnt + ONE;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hi_nx    = hi;
      complete = 1'b0;
      timeout  = 1'b0;
      case (state)
         IDLE: begin
            if (fall) state_nx = ARMED;
         end
         ARMED: begin
            if (rise) begin
               state_nx = HIGH;
               cnt_nx   = ONE;
            end
         end
         HIGH: begin
            if (fall) begin
               hi_nx    = cnt;
               state_nx = LOW;
               cnt_nx   = cnt_inc;
            end else if (cnt == TIMEOUT_V) begin
               timeout = 1'b1;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         LOW: begin
            if (rise) begin
               complete = 1'b1;
               state_nx = HIGH;
               cnt_nx   = ONE;
            end else if (cnt == TIMEOUT_V) begin
               timeout = 1'b1;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (timeout) state_nx = s ? IDLE : ARMED;
   end

   assign drop = complete & meas_valid & ~meas_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         meas_valid  <= 1'b0;
         meas_high   <= '0;
         meas_period <= '0;
         stuck       <= 1'b0;
         stuck_level <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (complete && !drop) begin
            meas_valid  <= 1'b1;
            meas_high   <= hi;
            meas_period <= cnt;
         end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
         end
         overrun <= drop | (overrun & ~clr_overrun);
         if (timeout) begin
            stuck       <= 1'b1;
            stuck_level <= s;
         end else if (state == ARMED && state_nx == HIGH) begin
            stuck <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized scoreboard bench for pwm_capture
// Model works on edge timestamps of the delayed input; monitor checks every cycle.
module tb_pwm_capture;

   localparam int CNT_W = 16;
   localparam int SYNC  = 2;
   localparam int TMO   = 1000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pwm_in = 1'b1;
   logic             meas_ready = 1'b0;
   logic             clr_overrun = 1'b0;
   logic             meas_valid;
   logic [CNT_W-1:0] meas_high;
   logic [CNT_W-1:0] meas_period;
   logic             stuck;
   logic             stuck_level;
   logic             overrun;

   always #5 clk = ~clk;

   pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in), .meas_ready(meas_ready),
      .meas_valid(meas_valid), .meas_high(meas_high), .meas_period(meas_period),
      .stuck(stuck), .stuck_level(stuck_level), .overrun(overrun),
      .clr_overrun(clr_overrun)
   );

   typedef struct {
      int high;
      int period;
   } res_t;

   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   run_mon = 0;
   bit   cur_rst = 1;
   bit   cur_ready = 0;

   // Expected outputs for the current cycle and for the next one.
   bit   m_valid, m_stuck, m_stuck_lvl, m_ov;
   bit   nx_valid, nx_stuck, nx_stuck_lvl, nx_ov;

   bit   hist_pwm[$];
   bit   hist_rst[$];
   bit   armed, tracking, fell, prev = 1;
   int   t_rise, t_fall, now_t = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input bit pw, input bit rdy, input bit clr, input bit r);
      bit   lvl, rise, fall, comp, drop;
      int   hv, pv;
      res_t rr;
      @(posedge clk);
      #1;
      m_valid = nx_valid; m_stuck = nx_stuck; m_stuck_lvl = nx_stuck_lvl; m_ov = nx_ov;
      pwm_in = pw; meas_ready = rdy; clr_overrun = clr; rst = r;
      cur_rst = r; cur_ready = rdy;
      // Level the DUT sees now: input from SYNC cycles ago, forced high by a recent reset.
      lvl = 1'b1;
      if (hist_pwm.size() == SYNC) begin
         lvl = hist_pwm[0];
         foreach (hist_rst[i]) if (hist_rst[i]) lvl = 1'b1;
      end
      hist_pwm.push_back(pw);
      hist_rst.push_back(r);
      if (hist_pwm.size() > SYNC) begin
         void'(hist_pwm.pop_front());
         void'(hist_rst.pop_front());
      end
      now_t++;
      comp = 0; hv = 0; pv = 0;
      if (r) begin
         armed = 0; tracking = 0; fell = 0; prev = 1;
         nx_valid = 0; nx_stuck = 0; nx_stuck_lvl = 0; nx_ov = 0;
         exp_q.delete();
      end else begin
         rise = lvl && !prev;
         fall = !lvl && prev;
         prev = lvl;
         nx_stuck = m_stuck; nx_stuck_lvl = m_stuck_lvl;
         if (tracking) begin
            if (fell && rise) begin
               comp = 1;
               hv = t_fall - t_rise;
               pv = (now_t - t_rise > TMO) ? TMO : now_t - t_rise;
               t_rise = now_t; fell = 0;
            end else if (!fell && fall) begin
               fell = 1; t_fall = now_t;
            end else if (now_t - t_rise >= TMO) begin
               tracking = 0; nx_stuck = 1; nx_stuck_lvl = lvl; armed = !lvl;
            end
         end else if (armed) begin
            if (rise) begin
               tracking = 1; fell = 0; t_rise = now_t; nx_stuck = 0;
            end
         end else if (fall) begin
            armed = 1;
         end
         drop = comp && m_valid && !rdy;
         if (comp && !drop) begin
            rr.high = hv; rr.period = pv;
            exp_q.push_back(rr);
            nx_valid = 1;
         end else if (m_valid && rdy) begin
            nx_valid = 0;
         end else begin
            nx_valid = m_valid;
         end
         nx_ov = drop ? 1'b1 : (clr ? 1'b0 : m_ov);
      end
   endtask

   // rmode: 0 ready high, 1 ready low, 2 random ready/clr, 3 ready only at completion, 4 ready + clr pulse
   task automatic run_wave(input int hi, input int lo, input int n, input int rmode);
      bit rdy, clr;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < hi + lo; i++) begin
            clr = 0;
            case (rmode)
               0: rdy = 1;
               1: rdy = 0;
               2: begin
                  rdy = 1'($urandom_range(0, 1));
                  clr = ($urandom_range(0, 15) == 0);
               end
               3: rdy = (i == SYNC);
               default: begin
                  rdy = 1;
                  clr = (k == 0 && i == 40);
               end
            endcase
            step(i < hi, rdy, clr, 0);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      @(negedge clk);
      check({tag, "_valid"}, int'(meas_valid), 0);
      check({tag, "_high"}, int'(meas_high), 0);
      check({tag, "_period"}, int'(meas_period), 0);
      check({tag, "_stuck"}, int'(stuck), 0);
      check({tag, "_stuck_level"}, int'(stuck_level), 0);
      check({tag, "_overrun"}, int'(overrun), 0);
   endtask

   always @(negedge clk) begin
      if (run_mon && !cur_rst) begin
         check("meas_valid", int'(meas_valid), int'(m_valid));
         if (meas_valid && m_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL result actual=%0d/%0d required=none at %0t",
                        meas_high, meas_period, $time);
            end else begin
               check("meas_high", int'(meas_high), exp_q[0].high);
               check("meas_period", int'(meas_period), exp_q[0].period);
               if (cur_ready) void'(exp_q.pop_front());
            end
         end
         check("stuck", int'(stuck), int'(m_stuck));
         check("stuck_level", int'(stuck_level), int'(m_stuck_lvl));
         check("overrun", int'(overrun), int'(m_ov));
      end
   end

   initial begin
      // Input high through reset, released 10 cycles before its fall.
      for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
      run_mon = 1;
      step(1, 1, 0, 0);
      check_all_zero("reset");
      for (int i = 0; i < 9; i++) step(1, 1, 0, 0);
      for (int i = 0; i < 70; i++) step(0, 1, 0, 0);
      run_wave(30, 70, 5, 0);
      // Consumer stalls across several completions, then drains and clears overrun.
      run_wave(30, 70, 3, 1);
      run_wave(30, 70, 2, 4);
      // Input stuck low mid-stream, then resumes.
      for (int i = 0; i < 1100; i++) step(0, 1, 0, 0);
      run_wave(30, 70, 3, 0);
      // Completions landing on a handshake cycle.
      run_wave(10, 10, 6, 3);
      run_wave(10, 10, 2, 0);
      // Reset while in the low phase.
      run_wave(30, 70, 2, 0);
      run_wave(30, 40, 1, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 0);
      check_all_zero("mid_reset");
      for (int i = 0; i < 28; i++) step(0, 1, 0, 0);
      run_wave(30, 70, 3, 0);
      // Random streams with occasional stuck segments and random consumer.
      for (int k = 0; k < 40; k++) begin
         int hi, lo;
         hi = $urandom_range(3, 80);
         lo = $urandom_range(3, 80);
         if (k % 13 == 5) lo = $urandom_range(1001, 1040);
         if (k % 13 == 9) hi = $urandom_range(1001, 1040);
         run_wave(hi, lo, 1, 2);
      end
      for (int i = 0; i < 200; i++) step(0, 1, 0, 0);
      @(negedge clk);
      check("leftover_results", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
